// File: rtl/dt_engine_param.sv
// dt_engine_param: two-pass chamfer distance transform over an IMG_W x IMG_H
// binary image. Each pixel is processed in a fetch / neighbour-read / write
// sequence: a forward raster pass, then a backward raster pass.
//
// Ports:
//   clk, reset (async, active-low)
//   start, mode        - transform request; mode 0 = 8-neighbour, 1 = 4-neighbour
//   busy, fwpass_finish, done - status levels
//   sti_rd/sti_addr/sti_di    - packed 1-bit pixel ROM (read on negedge)
//   res_rd/res_wr/res_addr/res_do/res_di - distance RAM (read on negedge,
//                                          write on posedge)
module dt_engine_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int DIST_W = 8,
  parameter int STI_AW = $clog2(IMG_W*IMG_H/STI_W),
  parameter int RES_AW = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              fwpass_finish,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [STI_W-1:0]  sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (STI_W > 1) ? $clog2(STI_W) : 1;

  localparam logic [XW-1:0]     XMAX  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     YMAX  = YW'(IMG_H - 1);
  localparam logic [BW-1:0]     BMAX  = BW'(STI_W - 1);
  localparam logic [RES_AW-1:0] PLAST = RES_AW'(IMG_W*IMG_H - 1);
  localparam logic [RES_AW-1:0] ROW   = RES_AW'(IMG_W);
  localparam logic [RES_AW-1:0] ONE   = RES_AW'(1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FW_FETCH = 4'd1;
  localparam logic [3:0] S_FW_NB    = 4'd2;
  localparam logic [3:0] S_FW_WR    = 4'd3;
  localparam logic [3:0] S_FW_END   = 4'd4;
  localparam logic [3:0] S_BW_FETCH = 4'd5;
  localparam logic [3:0] S_BW_NB    = 4'd6;
  localparam logic [3:0] S_BW_WR    = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [RES_AW-1:0] p_q, p_d;
  // b_q = p % STI_W and w_q = p / STI_W, tracked incrementally with p_q
  logic [BW-1:0]     b_q, b_d;
  logic [STI_AW-1:0] w_q, w_d;
  logic [STI_W-1:0]  word_q, word_d;
  logic [2:0]        nb_q, nb_d;
  logic [DIST_W-1:0] min_q, min_d;
  logic [DIST_W-1:0] own_q, own_d;
  logic              mode_q, mode_d;
  logic              fwfin_q, fwfin_d;

  logic is_bw, is_fetch, is_nb, fetch, pix, inb;
  logic go_w, go_e, go_n, go_s, nb_own, nb_last;
  logic [RES_AW-1:0] nb_addr;
  logic [DIST_W-1:0] inc, wr_val;

  assign is_bw    = (state_q == S_BW_FETCH) || (state_q == S_BW_NB) || (state_q == S_BW_WR);
  assign is_fetch = (state_q == S_FW_FETCH) || (state_q == S_BW_FETCH);
  assign is_nb    = (state_q == S_FW_NB) || (state_q == S_BW_NB);
  // First pixel of a word in scan direction: MSB side going forward, LSB side going backward
  assign fetch    = is_fetch && (b_q == (is_bw ? BMAX : '0));
  assign pix      = word_q[BMAX - b_q];

  // Neighbour schedule; the backward pass reads the pixel's own value first
  always_comb begin
    go_w = 1'b0; go_e = 1'b0; go_n = 1'b0; go_s = 1'b0;
    nb_own = 1'b0; nb_last = 1'b0;
    case ({is_bw, mode_q})
      2'b00: case (nb_q)
        3'd0:    begin go_n = 1'b1; go_w = 1'b1; end
        3'd1:    go_n = 1'b1;
        3'd2:    begin go_n = 1'b1; go_e = 1'b1; end
        default: begin go_w = 1'b1; nb_last = 1'b1; end
      endcase
      2'b01: case (nb_q)
        3'd0:    go_n = 1'b1;
        default: begin go_w = 1'b1; nb_last = 1'b1; end
      endcase
      2'b10: case (nb_q)
        3'd0:    nb_own = 1'b1;
        3'd1:    go_e = 1'b1;
        3'd2:    begin go_s = 1'b1; go_w = 1'b1; end
        3'd3:    go_s = 1'b1;
        default: begin go_s = 1'b1; go_e = 1'b1; nb_last = 1'b1; end
      endcase
      default: case (nb_q)
        3'd0:    nb_own = 1'b1;
        3'd1:    go_e = 1'b1;
        default: begin go_s = 1'b1; nb_last = 1'b1; end
      endcase
    endcase
  end

  assign inb = !(go_w && x_q == '0) && !(go_e && x_q == XMAX) &&
               !(go_n && y_q == '0) && !(go_s && y_q == YMAX);
  assign nb_addr = p_q + (go_e ? ONE : '0) - (go_w ? ONE : '0)
                       + (go_s ? ROW : '0) - (go_n ? ROW : '0);

  assign inc    = (min_q == '1) ? min_q : min_q + DIST_W'(1);
  assign wr_val = is_bw ? ((own_q < inc) ? own_q : inc) : (pix ? inc : '0);

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign fwpass_finish = fwfin_q;
  assign sti_rd        = fetch;
  assign sti_addr      = w_q;
  assign res_rd        = is_nb && pix && inb;
  assign res_wr        = (state_q == S_FW_WR) || ((state_q == S_BW_WR) && pix);
  assign res_addr      = res_rd ? nb_addr : (res_wr ? p_q : '0);
  assign res_do        = res_wr ? wr_val : '0;

  always_comb begin
    state_d = state_q; x_d = x_q; y_d = y_q; p_d = p_q; b_d = b_q; w_d = w_q;
    word_d = word_q; nb_d = nb_q; min_d = min_q; own_d = own_q;
    mode_d = mode_q; fwfin_d = fwfin_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_FW_FETCH;
        x_d = '0; y_d = '0; p_d = '0; b_d = '0; w_d = '0;
        mode_d = mode; fwfin_d = 1'b0;
      end
      S_FW_FETCH, S_BW_FETCH: begin
        if (fetch) word_d = sti_di;
        min_d   = '1;
        nb_d    = '0;
        state_d = is_bw ? S_BW_NB : S_FW_NB;
      end
      S_FW_NB, S_BW_NB: begin
        if (!pix) begin
          state_d = is_bw ? S_BW_WR : S_FW_WR;
        end else begin
          // out-of-image neighbours count as distance 0
          if (nb_own)              own_d = res_di;
          else if (!inb)           min_d = '0;
          else if (res_di < min_q) min_d = res_di;
          nb_d = nb_q + 3'd1;
          if (nb_last) state_d = is_bw ? S_BW_WR : S_FW_WR;
        end
      end
      S_FW_WR: begin
        if (p_q == PLAST) begin
          state_d = S_FW_END;
          fwfin_d = 1'b1;
        end else begin
          state_d = S_FW_FETCH;
          p_d = p_q + ONE;
          if (x_q == XMAX) begin x_d = '0; y_d = y_q + YW'(1); end
          else x_d = x_q + XW'(1);
          if (b_q == BMAX) begin b_d = '0; w_d = w_q + STI_AW'(1); end
          else b_d = b_q + BW'(1);
        end
      end
      S_FW_END: state_d = S_BW_FETCH;
      S_BW_WR: begin
        if (p_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BW_FETCH;
          p_d = p_q - ONE;
          if (x_q == '0) begin x_d = XMAX; y_d = y_q - YW'(1); end
          else x_d = x_q - XW'(1);
          if (b_q == '0) begin b_d = BMAX; w_d = w_q - STI_AW'(1); end
          else b_d = b_q - BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q <= '0; y_q <= '0; p_q <= '0; b_q <= '0; w_q <= '0;
      word_q <= '0; nb_q <= '0; min_q <= '0; own_q <= '0;
      mode_q <= 1'b0; fwfin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d; y_q <= y_d; p_q <= p_d; b_q <= b_d; w_q <= w_d;
      word_q <= word_d; nb_q <= nb_d; min_q <= min_d; own_q <= own_d;
      mode_q <= mode_d; fwfin_q <= fwfin_d;
    end
  end

endmodule

// File: tb/tb_dt_engine_param.sv
// Testbench for dt_engine_param on a 16x16 image with 3-bit distances.
// Expected distances come from a brute-force nearest-background search
// (chessboard or city-block metric, pixels outside the image are background),
// clipped to the saturation value.
module tb_dt_engine_param;
  localparam int W    = 16;
  localparam int H    = 16;
  localparam int SW   = 8;
  localparam int DW   = 3;
  localparam int N    = W*H;
  localparam int NWD  = N/SW;
  localparam int SAW  = $clog2(NWD);
  localparam int RAW  = $clog2(N);
  localparam int MAXD = (1 << DW) - 1;

  logic           clk = 1'b0;
  logic           reset, start, mode;
  logic           busy, fwpass_finish, done;
  logic           sti_rd, res_rd, res_wr;
  logic [SAW-1:0] sti_addr;
  logic [SW-1:0]  sti_di = '0;
  logic [RAW-1:0] res_addr;
  logic [DW-1:0]  res_do;
  logic [DW-1:0]  res_di = '0;

  logic [SW-1:0] rom [NWD];
  logic [DW-1:0] ram [N];
  bit            img [N];
  logic          scramble = 1'b0;
  int            fw_wr_cnt = 0;
  logic          overlap = 1'b0;
  int            total = 0;
  int            passed = 0;
  int            fails = 0;

  dt_engine_param #(
    .IMG_W (W),
    .IMG_H (H),
    .STI_W (SW),
    .DIST_W(DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .busy         (busy),
    .fwpass_finish(fwpass_finish),
    .done         (done),
    .sti_rd       (sti_rd),
    .sti_addr     (sti_addr),
    .sti_di       (sti_di),
    .res_rd       (res_rd),
    .res_wr       (res_wr),
    .res_addr     (res_addr),
    .res_do       (res_do),
    .res_di       (res_di)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sti_rd) sti_di <= rom[sti_addr];
    if (res_rd) res_di <= ram[res_addr];
  end

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < N; i++) ram[i] <= DW'($urandom);
      fw_wr_cnt <= 0;
      overlap   <= 1'b0;
    end else begin
      if (res_wr) ram[res_addr] <= res_do;
      if (res_wr && !fwpass_finish) fw_wr_cnt <= fw_wr_cnt + 1;
      if (res_rd && res_wr) overlap <= 1'b1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_dist(input int x, input int y, input bit m);
    int d, dx, dy, dd;
    if (!img[y*W + x]) return 0;
    d = x + 1;
    if (y + 1 < d) d = y + 1;
    if (W - x < d) d = W - x;
    if (H - y < d) d = H - y;
    for (int q = 0; q < N; q++) begin
      if (!img[q]) begin
        dx = q % W - x; dy = q / W - y;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        dd = m ? dx + dy : ((dx > dy) ? dx : dy);
        if (dd < d) d = dd;
      end
    end
    return (d > MAXD) ? MAXD : d;
  endfunction

  function automatic int mism(input bit m);
    int n = 0;
    for (int p = 0; p < N; p++)
      if (int'(ram[p]) != ref_dist(p % W, p / W, m)) n++;
    return n;
  endfunction

  function automatic int rd(input int x, input int y);
    return int'(ram[y*W + x]);
  endfunction

  task automatic clear_img();
    for (int p = 0; p < N; p++) img[p] = 1'b0;
  endtask

  task automatic rect(input int x0, input int y0, input int x1, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y*W + x] = 1'b1;
  endtask

  task automatic rand_img(input int pct);
    for (int p = 0; p < N; p++) img[p] = ($urandom_range(99) < pct);
  endtask

  // Load ROM from the image (MSB = leftmost pixel) and fill RAM with garbage
  task automatic prep();
    logic [SW-1:0] wv;
    for (int w = 0; w < NWD; w++) begin
      wv = '0;
      for (int k = 0; k < SW; k++) wv[SW-1-k] = img[w*SW + k];
      rom[w] = wv;
    end
    @(negedge clk) scramble = 1'b1;
    @(negedge clk) scramble = 1'b0;
  endtask

  task automatic pulse_start(input bit m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
  endtask

  // Forward-pass image for an all-object image under the 4-neighbour metric
  task automatic fw_ones_checks();
    int n = 0;
    int e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e = ((x < y) ? x : y) + 1;
        if (e > MAXD) e = MAXD;
        if (rd(x, y) != e) n++;
      end
    chk("fw_ones_00", rd(0, 0), 1);
    chk("fw_ones_ff", rd(W-1, H-1), MAXD);
    chk("fw_ones_full", n, 0);
  endtask

  task automatic finish_run(input string tag, input bit m, input bit fw_ones);
    int  n = 0;
    bit  seen = 1'b0;
    int  snap = -1;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
      if (fwpass_finish && !seen && !done) begin
        seen = 1'b1;
        snap = fw_wr_cnt;
        if (fw_ones) fw_ones_checks();
      end
    end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_fw_writes"}, snap, N);
    chk({tag, "_busy_low"}, int'(busy), 0);
    chk({tag, "_fwfin_high"}, int'(fwpass_finish), 1);
    chk({tag, "_rd_wr_excl"}, int'(overlap), 0);
    chk({tag, "_ram_mismatches"}, mism(m), 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", int'({busy, fwpass_finish, done, sti_rd, res_rd, res_wr}), 0);
    chk("reset_addr", int'(res_addr) + int'(sti_addr) + int'(res_do), 0);
    @(negedge clk) reset = 1'b1;

    clear_img(); prep(); pulse_start(1'b0);
    finish_run("zero", 1'b0, 1'b0);

    clear_img(); img[8*W + 8] = 1'b1; prep(); pulse_start(1'b0);
    finish_run("single", 1'b0, 1'b0);
    chk("single_px", rd(8, 8), 1);

    clear_img(); rect(5, 5, 9, 9); prep(); pulse_start(1'b0);
    finish_run("sq_m0", 1'b0, 1'b0);
    chk("sq_m0_centre", rd(7, 7), 3);
    chk("sq_m0_ring", rd(6, 6), 2);
    chk("sq_m0_border", rd(5, 5), 1);

    prep(); pulse_start(1'b1);
    finish_run("sq_m1", 1'b1, 1'b0);
    chk("sq_m1_centre", rd(7, 7), 3);
    chk("sq_m1_diag", rd(6, 6), 2);
    chk("sq_m1_corner", rd(5, 5), 1);

    clear_img(); rect(0, 5, W-1, 5); prep(); pulse_start(1'b1);
    finish_run("bar1", 1'b1, 1'b0);
    chk("bar1_left", rd(0, 5), 1);
    chk("bar1_right", rd(W-1, 5), 1);

    clear_img(); rect(0, 5, W-1, 7); prep(); pulse_start(1'b1);
    finish_run("bar3", 1'b1, 1'b0);
    chk("bar3_mid", rd(3, 6), 2);

    clear_img(); rect(0, 0, W-1, H-1); prep(); pulse_start(1'b1);
    finish_run("ones", 1'b1, 1'b1);
    chk("ones_interior_sat", rd(8, 8), MAXD);
    chk("ones_corner", rd(0, 0), 1);

    for (int i = 0; i < 4; i++) begin
      rand_img(40 + 15*i); prep(); pulse_start(i[0]);
      finish_run($sformatf("rand%0d", i), i[0], 1'b0);
    end

    // start (with the other mode) while busy must be ignored
    rand_img(70); prep(); pulse_start(1'b0);
    repeat (40) @(negedge clk);
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", int'(busy), 1);
    finish_run("ignored_start", 1'b0, 1'b0);

    // reset in the middle of the forward pass, then a clean re-run
    rand_img(60); prep(); pulse_start(1'b1);
    repeat (60) @(negedge clk);
    chk("midrun_in_fw", int'({busy, fwpass_finish}), 2);
    #2 reset = 1'b0;
    #1 chk("midrun_reset_outs", int'({busy, sti_rd, res_rd, res_wr, done, fwpass_finish}), 0);
    @(negedge clk) reset = 1'b1;
    prep(); pulse_start(1'b1);
    finish_run("restart", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dt_engine_param.md
Name: dt_engine_param

Overview:
- Parametrised two-pass chamfer distance-transform engine for binary images of IMG_W x IMG_H pixels.
- Reads packed 1-bit pixels from the stimulus ROM and writes DIST_W-bit distances to the result RAM.
- Runtime mode selects an 8-neighbour (chessboard) or 4-neighbour (city-block) metric.
- Successor to the fixed 128x128 DT core; same ROM/RAM bus timing, plus a start/busy handshake, a metric select and saturation.

Parameters:
IMG_W, 128, image width in pixels; must be a multiple of STI_W
IMG_H, 128, image height in pixels
STI_W, 16, pixels per ROM word
DIST_W, 8, bits per distance value
STI_AW, clog2(IMG_W*IMG_H/STI_W), ROM address width
RES_AW, clog2(IMG_W*IMG_H), RAM address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a transform
mode  in  1  0 = 8-neighbour metric, 1 = 4-neighbour metric; sampled on accepted start
busy  out  1  high from accepted start until done rises
fwpass_finish  out  1  forward pass complete; level
done  out  1  both passes complete; level
sti_rd  out  1  ROM read enable
sti_addr  out  STI_AW  ROM word address
sti_di  in  STI_W  ROM data
res_rd  out  1  RAM read enable
res_wr  out  1  RAM write enable
res_addr  out  RES_AW  RAM address
res_do  out  DIST_W  RAM write data
res_di  in  DIST_W  RAM read data

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0. RAM contents are untouched.
- Memory timing:
  - ROM and RAM are read on the negedge when rd is high, so read data is valid at the next posedge.
  - RAM writes on the posedge when res_wr=1.
  - res_rd and res_wr are never high in the same cycle.
- Pixel mapping:
  - Pixel (x,y) has linear index p = y*IMG_W + x.
  - ROM word p/STI_W holds the pixel at bit STI_W-1-(p%STI_W), i.e. MSB is leftmost. 1 = object.
  - Distance for (x,y) is stored at RAM address p.
- Neighbours outside the image read as 0.
- Increment: +1 saturates at 2^DIST_W-1.
- Start handshake:
  - start is accepted only in IDLE or DONE.
  - Acceptance clears done and fwpass_finish, sets busy and latches mode.
  - start while busy is ignored.
- States: IDLE -> FW_FETCH -> FW_NB -> FW_WR -> (FW_FETCH | FW_END) -> BW_FETCH -> BW_NB -> BW_WR -> (BW_FETCH | DONE).
- FW_FETCH: on a word boundary, issue sti_rd for the current word and latch it on the next posedge; otherwise reuse the latched word.
- Forward pass (raster order, p = 0 up to IMG_W*IMG_H-1):
  - Background pixel: write 0.
  - Object pixel: read neighbours in FW_NB, one res_rd per cycle.
  - mode 0 reads NW, N, NE, W; mode 1 reads N, W.
  - Write min(neighbours)+1.
  - Every pixel is written exactly once.
- FW_END: fwpass_finish goes to 1 and stays high. The next cycle enters the backward pass.
- Backward pass (p = IMG_W*IMG_H-1 down to 0):
  - Background pixel: no write.
  - Object pixel: reads the pixel's own forward value plus neighbours.
  - mode 0 reads E, SW, S, SE; mode 1 reads E, S.
  - Write min(own, min(neighbours)+1).
- DONE: done=1 and busy=0, both held until the next accepted start.
- Scan wrap-around: the x counter wraps at IMG_W-1 and steps y. Termination is exact on the last pixel with no extra writes.
- Reset mid-operation: returns immediately to IDLE with rd/wr deasserted. Partial RAM results remain.

Test Plan:
- All-zero ROM, mode 0, start -> all IMG_W*IMG_H RAM words = 0; fwpass_finish then done both high; busy low after done.
- Single object pixel at (64,64), mode 0 -> res[8256]=1; all other words 0.
- 5x5 object square at x=10..14, y=10..14, mode 0 -> centre (12,12)=3, ring at distance 1 from centre = 2, border = 1. Mode 1 -> centre 3, (11,11)=2, (10,10)=1.
- Object bar occupying row 20, x=0..127, mode 1 -> all 1. Same bar in rows 20..22 -> row 21 = 2.
- DIST_W=3, IMG_W=IMG_H=32, ROM all ones, mode 1 -> after the forward pass (0,0)=1 and (31,31)=7 (saturated); after done, interior (16,16)=7 and (0,0)=1.
- Corner and robustness checks:
  - start pulsed while busy -> ignored; the result is identical to an uninterrupted run.
  - reset asserted mid forward pass -> busy, sti_rd, res_wr and done = 0 at once.
  - Re-start after reset -> correct full result.
